// File: rtl/i2c_target_pkg.sv
// Shared types and defaults for the I2C ADC-emulating target.
// State encoding, pointer codes and reset defaults live here.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic [1:0]  PTR_CONV       = 2'b00;
    localparam logic [1:0]  PTR_CONFIG     = 2'b01;
    localparam logic [6:0]  DEFAULT_ADDR   = 7'h48;
    localparam logic [15:0] DEFAULT_CONFIG = 16'h8583;

    function automatic logic [7:0] byte_of(input logic [15:0] word, input logic lsb);
        return lsb ? word[7:0] : word[15:8];
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP strobes.
// Latency SYNC_STAGES+1 cycles pin-to-strobe; no backpressure (free-running).
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise_out,
    output logic scl_fall_out,
    output logic start_out,
    output logic stop_out,
    output logic sda_out
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   r_scl_rise;
    logic                   r_scl_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   r_sda;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Idle bus is high, so the chain resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sda      <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_prev;
            r_scl_fall <= ~w_scl & r_scl_prev;
            r_start    <= w_scl & r_scl_prev & r_sda_prev & ~w_sda;
            r_stop     <= w_scl & r_scl_prev & ~r_sda_prev & w_sda;
            r_sda      <= w_sda;
        end
    end

    assign scl_rise_out = r_scl_rise;
    assign scl_fall_out = r_scl_fall;
    assign start_out    = r_start;
    assign stop_out     = r_stop;
    assign sda_out      = r_sda;

endmodule

// File: rtl/i2c_adc_target.sv
// I2C target emulating a pointer/conversion/config ADC; SDA sampled on SCL rise, driven on SCL fall.
// Reacts SYNC_STAGES+2 cycles after a pin edge; no backpressure (sample_valid_in always accepted).
module i2c_adc_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDR  = DEFAULT_ADDR,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [15:0] CONFIG_RESET = DEFAULT_CONFIG
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    input  logic [15:0] sample_data_in,
    input  logic        sample_valid_in,
    output logic [15:0] config_out,
    output logic        config_wr_out,
    output logic        conv_rd_out
);

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic        r_rw;
    logic        r_phase;
    logic        r_byte_sel;
    logic [1:0]  r_wr_idx;
    logic [1:0]  r_ptr;
    logic [7:0]  r_msb;
    logic [15:0] r_conv;
    logic [15:0] r_shadow;
    logic [15:0] r_config;
    logic        r_sda_oe;
    logic        r_config_wr;
    logic        r_conv_rd;

    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_sda;
    logic [7:0]  w_byte;
    logic [15:0] w_rd_sel;
    logic [7:0]  w_rd_byte;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .scl_rise_out (w_scl_rise),
        .scl_fall_out (w_scl_fall),
        .start_out    (w_start),
        .stop_out     (w_stop),
        .sda_out      (w_sda)
    );

    assign w_byte    = {r_shift, w_sda};
    assign w_rd_sel  = (r_ptr == PTR_CONFIG) ? r_config : r_conv;
    assign w_rd_byte = byte_of(r_shadow, r_byte_sel);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_rw        <= 1'b0;
            r_phase     <= 1'b0;
            r_byte_sel  <= 1'b0;
            r_wr_idx    <= 2'd0;
            r_ptr       <= PTR_CONV;
            r_msb       <= 8'd0;
            r_conv      <= 16'd0;
            r_shadow    <= 16'd0;
            r_config    <= CONFIG_RESET;
            r_sda_oe    <= 1'b0;
            r_config_wr <= 1'b0;
            r_conv_rd   <= 1'b0;
        end else begin
            r_config_wr <= 1'b0;
            r_conv_rd   <= 1'b0;
            if (sample_valid_in) r_conv <= sample_data_in;

            if (w_stop) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                r_phase  <= 1'b0;
                r_wr_idx <= 2'd0;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_bit_cnt <= 3'd0;
                r_sda_oe  <= 1'b0;
                r_phase   <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rw     <= w_sda;
                            r_wr_idx <= 2'd0;
                            r_phase  <= 1'b0;
                            r_state  <= (w_byte[7:1] == DEVICE_ADDR) ? ADDR_ACK : IGNORE;
                        end
                    end
                    // First fall after bit 8 drives ACK, the next one hands over to the data phase.
                    ADDR_ACK: if (w_scl_fall) begin
                        if (!r_phase) begin
                            r_sda_oe <= 1'b1;
                            r_phase  <= 1'b1;
                        end else begin
                            r_phase   <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            if (r_rw) begin
                                r_state    <= RD_BYTE;
                                r_shadow   <= w_rd_sel;
                                r_byte_sel <= 1'b0;
                                r_sda_oe   <= ~w_rd_sel[15];
                                r_conv_rd  <= (r_ptr == PTR_CONV);
                            end else begin
                                r_state  <= WR_BYTE;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    WR_BYTE: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_phase <= 1'b0;
                            case (r_wr_idx)
                                2'd0: begin
                                    if (w_byte < 8'd2) begin
                                        r_ptr    <= w_byte[1:0];
                                        r_wr_idx <= 2'd1;
                                        r_state  <= WR_ACK;
                                    end else begin
                                        r_state  <= IGNORE;
                                    end
                                end
                                2'd1: begin
                                    r_msb    <= w_byte;
                                    r_wr_idx <= 2'd2;
                                    r_state  <= WR_ACK;
                                end
                                default: begin
                                    if (r_ptr == PTR_CONFIG) begin
                                        r_config    <= {r_msb, w_byte};
                                        r_config_wr <= 1'b1;
                                    end
                                    r_wr_idx <= 2'd1;
                                    r_state  <= WR_ACK;
                                end
                            endcase
                        end
                    end
                    WR_ACK: if (w_scl_fall) begin
                        if (!r_phase) begin
                            r_sda_oe <= 1'b1;
                            r_phase  <= 1'b1;
                        end else begin
                            r_sda_oe  <= 1'b0;
                            r_phase   <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_state   <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= RD_ACK;
                                r_phase <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_sda_oe <= ~w_rd_byte[3'd7 - r_bit_cnt];
                        end
                    end
                    // r_phase marks a sampled controller ACK; the following fall starts the next byte.
                    RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= IGNORE;
                            end else begin
                                r_phase    <= 1'b1;
                                r_byte_sel <= ~r_byte_sel;
                            end
                        end else if (w_scl_fall) begin
                            if (r_phase) begin
                                r_state   <= RD_BYTE;
                                r_phase   <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_sda_oe  <= ~w_rd_byte[7];
                            end else begin
                                r_sda_oe  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe_out    = r_sda_oe;
    assign config_out    = r_config;
    assign config_wr_out = r_config_wr;
    assign conv_rd_out   = r_conv_rd;

endmodule

// File: tb/tb_i2c_adc_target.sv
// Bench for i2c_adc_target: bit-level I2C controller, transaction-level register model.
`timescale 1ns/1ps
module tb_i2c_adc_target;

    localparam int Q = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        tb_sda_low = 1'b0;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] sample_data = 16'd0;
    logic        sample_valid = 1'b0;
    logic [15:0] config_out;
    logic        config_wr;
    logic        conv_rd;

    int checks = 0;
    int failures = 0;
    int cnt_wr = 0;
    int cnt_rd = 0;
    int cnt_oe = 0;
    logic prev_scl = 1'b1;
    logic prev_oe  = 1'b0;
    bit   skip_stab = 1'b0;

    logic [1:0]  m_ptr  = 2'd0;
    logic [15:0] m_cfg  = 16'h8583;
    logic [15:0] m_conv = 16'h0000;
    logic [7:0]  q_wr[$];
    logic [7:0]  rd_bytes[8];

    assign sda_line = ~(sda_oe | tb_sda_low);

    always #5 clk = ~clk;

    i2c_adc_target dut (
        .clk_in          (clk),
        .reset_n_in      (rst_n),
        .scl_in          (scl),
        .sda_in          (sda_line),
        .sda_oe_out      (sda_oe),
        .sample_data_in  (sample_data),
        .sample_valid_in (sample_valid),
        .config_out      (config_out),
        .config_wr_out   (config_wr),
        .conv_rd_out     (conv_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: pulse/drive counters and SDA stability while SCL is high.
    always @(negedge clk) begin
        if (config_wr) cnt_wr++;
        if (conv_rd)   cnt_rd++;
        if (sda_oe)    cnt_oe++;
        if (rst_n && !skip_stab && scl && prev_scl) begin
            checks++;
            if (sda_oe !== prev_oe) begin
                failures++;
                $display("FAIL sda_stable_scl_high: sda_oe_out=%0b previously %0b", sda_oe, prev_oe);
            end
        end
        prev_scl = scl;
        prev_oe  = sda_oe;
    end

    task automatic bus_start();
        tb_sda_low = 1'b0; #Q; scl = 1'b1; #Q; tb_sda_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1; #Q; scl = 1'b1; #Q; tb_sda_low = 1'b0; #Q;
    endtask

    task automatic put_bit(input logic b);
        tb_sda_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        tb_sda_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(a);
        ack = ~a;
    endtask

    task automatic get_byte(output logic [7:0] v, input logic ack);
        logic b;
        v = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(~ack);
    endtask

    task automatic pulse_sample(input logic [15:0] v);
        @(negedge clk);
        sample_data  = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        m_conv = v;
    endtask

    // Write transaction of the bytes in q_wr (address first); model decides every ACK.
    task automatic write_tx(input string tag);
        logic       ack;
        logic       exp_ack;
        logic [7:0] b;
        logic [7:0] msb;
        int         base_wr, base_rd, base_oe, exp_wr;
        bit         addr_match;
        base_wr = cnt_wr; base_rd = cnt_rd; base_oe = cnt_oe; exp_wr = 0; msb = 8'd0;
        addr_match = (q_wr[0][7:1] == 7'h48);
        bus_start();
        for (int i = 0; i < q_wr.size(); i++) begin
            b = q_wr[i];
            if (i == 0)      exp_ack = addr_match;
            else if (i == 1) exp_ack = (b < 8'd2);
            else             exp_ack = 1'b1;
            put_byte(b, ack);
            check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
            if (!exp_ack) break;
            if (i == 1) m_ptr = b[1:0];
            else if (i >= 2 && (i % 2) == 0) msb = b;
            else if (i >= 3 && m_ptr == 2'd1) begin
                m_cfg = {msb, b};
                exp_wr++;
            end
        end
        bus_stop();
        #(4*Q);
        check({tag, "_config"}, 32'(config_out), 32'(m_cfg));
        check({tag, "_cfg_wr_cnt"}, 32'(cnt_wr - base_wr), 32'(exp_wr));
        check({tag, "_conv_rd_cnt"}, 32'(cnt_rd - base_rd), 32'd0);
        if (!addr_match) check({tag, "_oe_cycles"}, 32'(cnt_oe - base_oe), 32'd0);
    endtask

    // Read transaction of nbytes; optional sample update after byte inj_after.
    task automatic read_tx(input string tag, input int nbytes, input int inj_after,
                           input logic [15:0] inj_val);
        logic        ack;
        logic [7:0]  v;
        logic [15:0] snap;
        int          base_rd, exp_rd;
        base_rd = cnt_rd;
        bus_start();
        put_byte(8'h91, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'd1);
        snap   = (m_ptr == 2'd1) ? m_cfg : m_conv;
        exp_rd = (m_ptr == 2'd0) ? 1 : 0;
        for (int k = 0; k < nbytes; k++) begin
            get_byte(v, k < nbytes - 1);
            rd_bytes[k] = v;
            check({tag, "_byte"}, 32'(v), 32'((k % 2) ? snap[7:0] : snap[15:8]));
            if (k == inj_after) pulse_sample(inj_val);
        end
        bus_stop();
        #(4*Q);
        check({tag, "_conv_rd_cnt"}, 32'(cnt_rd - base_rd), 32'(exp_rd));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ack;
        logic [7:0]  ptr;
        int          nd, op;

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_config", 32'(config_out), 32'h8583);
        check("reset_wr_pulses", 32'(cnt_wr), 32'd0);
        check("reset_rd_pulses", 32'(cnt_rd), 32'd0);

        q_wr = '{8'h90, 8'h01, 8'h42, 8'h43};
        write_tx("cfg_write");
        check("cfg_write_literal", 32'(config_out), 32'h4243);

        pulse_sample(16'h1234);
        q_wr = '{8'h90, 8'h00};
        write_tx("ptr_conv");
        read_tx("conv_read", 3, -1, 16'h0);
        check("conv_msb_literal", 32'(rd_bytes[0]), 32'h12);
        check("conv_lsb_literal", 32'(rd_bytes[1]), 32'h34);
        check("conv_wrap_literal", 32'(rd_bytes[2]), 32'h12);

        q_wr = '{8'h92, 8'h01, 8'h55};
        write_tx("bad_addr");

        q_wr = '{8'h90, 8'h01, 8'hAA};
        write_tx("partial");
        check("partial_literal", 32'(config_out), 32'h4243);

        q_wr = '{8'h90, 8'h00};
        write_tx("ptr_zero");
        q_wr = '{8'h90, 8'h05};
        write_tx("bad_ptr");
        read_tx("after_bad_ptr", 2, -1, 16'h0);

        read_tx("mid_sample", 2, 0, 16'hBEEF);
        check("mid_sample_literal", 32'({rd_bytes[0], rd_bytes[1]}), 32'h1234);
        read_tx("new_sample", 2, -1, 16'h0);
        check("new_sample_literal", 32'({rd_bytes[0], rd_bytes[1]}), 32'hBEEF);

        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                pulse_sample(16'($urandom));
                read_tx("rnd_read", $urandom_range(1, 4), $urandom_range(0, 4), 16'($urandom));
            end else if (op == 1) begin
                q_wr.delete();
                q_wr.push_back(($urandom_range(0, 5) == 0) ? {7'($urandom), 1'b0} : 8'h90);
                ptr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
                q_wr.push_back(ptr);
                nd = $urandom_range(0, 4);
                for (int d = 0; d < nd; d++) q_wr.push_back(8'($urandom));
                write_tx("rnd_write");
            end else begin
                read_tx("rnd_read2", $urandom_range(1, 3), -1, 16'h0);
            end
        end

        q_wr = '{8'h90, 8'h00};
        write_tx("pre_reset_ptr");
        pulse_sample(16'h1234);
        bus_start();
        put_byte(8'h91, ack);
        check("pre_reset_addr_ack", 32'(ack), 32'd1);
        check("pre_reset_driving", 32'(sda_oe), 32'd1);
        skip_stab = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_read_oe", 32'(sda_oe), 32'd0);
        #20;
        scl = 1'b1;
        tb_sda_low = 1'b0;
        #Q;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 2'd0; m_cfg = 16'h8583; m_conv = 16'h0000;
        repeat (10) @(negedge clk);
        skip_stab = 1'b0;
        check("post_reset_config", 32'(config_out), 32'h8583);
        q_wr = '{8'h90, 8'h01};
        write_tx("post_reset_ptr");
        read_tx("post_reset_cfg_read", 2, -1, 16'h0);
        check("post_reset_cfg_literal", 32'({rd_bytes[0], rd_bytes[1]}), 32'h8583);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
